// File: rtl/hilo_muldiv.sv
// HI/LO register unit: single-cycle MTHI/MTLO/MULT/MULTU and 1-bit/cycle restoring DIV/DIVU.
// Optional macro HILO_FWD_EN forwards same-cycle MTxx/MULT writes onto hi_o/lo_o.
module hilo_muldiv #(
    parameter int WIDTH     = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             hlwrite_i,
    input  logic [5:0]       funct_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = (DIV_ITERS > 1) ? $clog2(DIV_ITERS) : 1;

    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t            state, state_nx;
    logic [WIDTH-1:0]  hi, lo;
    logic [WIDTH-1:0]  quo, rem, dvs;
    logic [CW-1:0]     cnt;
    logic              neg_q, neg_r;

    logic              accept, start_div, is_signed_div, last_iter;
    logic              wr_hi, wr_lo;
    logic [WIDTH-1:0]  new_hi, new_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]  a_abs, b_abs;
    logic [WIDTH:0]    shifted, diff;
    logic [WIDTH-1:0]  quo_nx, rem_nx, q_fix, r_fix;

    // Decode of the presented op and the single-cycle HI/LO write values
    always_comb begin
        accept        = (state == ST_IDLE) && hlwrite_i && !flush_i;
        start_div     = accept && ((funct_i == F_DIV) || (funct_i == F_DIVU));
        is_signed_div = (funct_i == F_DIV);
        if (funct_i == F_MULT)
            prod = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
        else
            prod = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
        wr_hi  = accept && ((funct_i == F_MTHI) || (funct_i == F_MULT) || (funct_i == F_MULTU));
        wr_lo  = accept && ((funct_i == F_MTLO) || (funct_i == F_MULT) || (funct_i == F_MULTU));
        new_hi = (funct_i == F_MTHI) ? a_i : prod[2*WIDTH-1:WIDTH];
        new_lo = (funct_i == F_MTLO) ? a_i : prod[WIDTH-1:0];
        a_abs  = (is_signed_div && a_i[WIDTH-1]) ? -a_i : a_i;
        b_abs  = (is_signed_div && b_i[WIDTH-1]) ? -b_i : b_i;
    end

    // One restoring step: shift in the next dividend bit, subtract if it fits
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        if (!diff[WIDTH]) begin
            rem_nx = diff[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = shifted[WIDTH-1:0];
            quo_nx = {quo[WIDTH-2:0], 1'b0};
        end
        q_fix     = neg_q ? -quo_nx : quo_nx;
        r_fix     = neg_r ? -rem_nx : rem_nx;
        last_iter = (cnt == CW'(DIV_ITERS - 1));
    end

    // Next-state logic; stall is raised combinationally in the accept cycle
    always_comb begin
        state_nx = state;
        stall_o  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_div) begin
                    state_nx = ST_DIV;
                    stall_o  = 1'b1;
                end
            end
            ST_DIV: begin
                stall_o = 1'b1;
                if (flush_i)
                    state_nx = ST_IDLE;
                else if (last_iter)
                    state_nx = ST_DONE;
            end
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            state <= ST_IDLE;
        else
            state <= state_nx;
    end

    // Divider datapath: operand magnitudes and result signs are captured on accept
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            quo   <= '0;
            rem   <= '0;
            dvs   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start_div) begin
            quo   <= a_abs;
            rem   <= '0;
            dvs   <= b_abs;
            cnt   <= '0;
            neg_q <= is_signed_div && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_r <= is_signed_div && a_i[WIDTH-1];
        end else if (state == ST_DIV && !flush_i) begin
            quo <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt + 1'b1;
        end
    end

    // Architectural HI/LO; a flush or zero divisor suppresses the divide write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi <= '0;
            lo <= '0;
        end else if (state == ST_DIV) begin
            if (!flush_i && last_iter && (dvs != '0)) begin
                hi <= r_fix;
                lo <= q_fix;
            end
        end else begin
            if (wr_hi)
                hi <= new_hi;
            if (wr_lo)
                lo <= new_lo;
        end
    end

    always_comb begin
`ifdef HILO_FWD_EN
        hi_o = wr_hi ? new_hi : hi;
        lo_o = wr_lo ? new_lo : lo;
`else
        hi_o = hi;
        lo_o = lo;
`endif
    end

endmodule
